uart_rx: RTL
============

# uart_rx

Receive-side UART core: recovers serial frames on `RX_IN` using oversampling and presents each good byte as a parallel word with a one-cycle valid strobe. It is the counterpart of the TX serializer path and sits between the pad-side RX line and the system-control/register block in the UART clock domain. Frame format is start(0), Data_width data bits LSB-first, optional parity, and one stop(1).

## Interface
- `Data_width`, default 8, number of data bits per frame.
- `CLK  in  1`: oversampling clock, Prescale cycles per bit.
- `RST  in  1`: **synchronous, active-low reset; one clock (`CLK`).**
- `RX_IN  in  1`: serial line, idles high.
- `Prescale  in  6`: oversampling ratio, legal values 8, 16, 32.
- `PAR_EN  in  1`: 1 means a parity bit follows the data bits.
- `PAR_TYP  in  1`: 0 selects even parity, 1 selects odd.
- `P_DATA  out  Data_width`: last good received word; holds until the next good frame.
- `Data_Valid  out  1`: one-cycle pulse when `P_DATA` updates.
- `Parity_Error  out  1`: one-cycle pulse, parity mismatch.
- `Stop_Error  out  1`: one-cycle pulse, stop bit sampled 0.

## Operation
- Reset (`RST`=0 at a `CLK` edge), including mid-frame:
  - state becomes IDLE, counters are 0, all outputs are 0 from the next cycle.
  - the partial frame is discarded.
- `Prescale`, `PAR_EN` and `PAR_TYP` are latched at start detection. Mid-frame changes are ignored. An illegal `Prescale` value is treated as 8.
- `edge_cnt` runs 0..Prescale-1 within each bit. `bit_cnt` indexes bits in the frame.
- Sampling: RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The majority of the three is the bit value, valid from edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: first edge at which RX_IN=0. That edge is frame edge 0 and edge_cnt=0.
  - START → IDLE at bit end if the sampled start bit is 1 (glitch). Nothing is reported.
  - START → DATA at bit end otherwise.
  - DATA: the sampled bit shifts into the MSB of the shift register (LSB-first line order). After Data_width bits, go to PARITY if PAR_EN, else STOP.
  - PARITY: the sampled bit is compared to the XOR of the data bits (inverted when PAR_TYP=1). The mismatch is stored. → STOP at bit end.
  - STOP: at bit end, go to IDLE.
    - If stop bit=1 and no parity mismatch: load `P_DATA`, pulse `Data_Valid`.
    - If stop bit=0: pulse `Stop_Error`.
    - If parity mismatch: pulse `Parity_Error`.
    - Both errors may pulse together.
    - `Data_Valid` is never asserted alongside an error, and `P_DATA` is unchanged on error.
- Back-to-back frames: IDLE accepts a start on the cycle after STOP ends.

## Timing
- Frame length N = (2 + Data_width + PAR_EN) × Prescale edges, counted from edge 0.
- Outputs are registered. The result/error pulse is high for exactly the cycle following edge N-1, i.e. it is set by edge N.
- Example: Data_width=8, PAR_EN=1, Prescale=8 gives N=88.
- The pulse width is always one cycle. There is no handshake: the consumer must capture on `Data_Valid`.
- A start-glitch rejection returns to IDLE at edge Prescale.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - legal prescale constants (8/16/32);
  - parity-type encodings.
- Sub-module `data_sampling`:
  - inputs: `CLK`, `RST`, `RX_IN`, `Prescale`, `edge_cnt`;
  - outputs: majority-voted `sampled_bit` and `sample_valid`.
- The top level holds the FSM, edge/bit counters, shift register, parity check and output registers.

## Test plan
- Data_width=8, Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 (parity bit 0) → `P_DATA`=0xA5, `Data_Valid` pulse set by edge 88, both errors 0.
- Prescale=32, PAR_EN=0, send 0x3C → `Data_Valid` set by edge 320, `P_DATA`=0x3C.
- Prescale=16, RX_IN low for 3 cycles then high → no pulses, FSM back in IDLE at edge 16, `P_DATA` unchanged.
- Prescale=8, PAR_EN=1, PAR_TYP=1, send 0x0F with parity bit 0 (correct is 1) → `Parity_Error` pulse, no `Data_Valid`, `P_DATA` keeps its previous value.
- Prescale=8, PAR_EN=0:
  - send 0x55 with stop bit 0 → `Stop_Error` pulse only;
  - then immediately send 0x81 correctly → `Data_Valid`, `P_DATA`=0x81.
- Prescale=16, PAR_EN=0, 1-cycle noise spike on one sample point of each data bit of 0xC3 → `P_DATA`=0xC3 (majority vote).
- Then assert RST for one edge mid-frame → all outputs 0, and the next full frame (0xC3) is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ==========================================================================
// uart_pkg : shared FSM encodings, prescale and parity constants for uart_rx
// rev 1.0
// ==========================================================================
`default_nettype none

package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_data_sampling.sv
// ==========================================================================
// data_sampling : three-point majority vote around the bit centre
// rev 1.0
// ==========================================================================
`default_nettype none

module data_sampling
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic [5:0] edge_cnt,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic [5:0] half;
  logic [2:0] samples_d;
  logic [2:0] samples_q;

  assign half = Prescale >> 1;

  always_comb begin
    samples_d = samples_q;
    if (edge_cnt == half - 6'd1) samples_d[0] = RX_IN;
    if (edge_cnt == half)        samples_d[1] = RX_IN;
    if (edge_cnt == half + 6'd1) samples_d[2] = RX_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST) samples_q <= 3'b000;
    else      samples_q <= samples_d;
  end

  assign sampled_bit  = (samples_q[0] & samples_q[1]) |
                        (samples_q[0] & samples_q[2]) |
                        (samples_q[1] & samples_q[2]);
  assign sample_valid = (edge_cnt >= half + 6'd2);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ==========================================================================
// uart_rx : oversampled UART receiver with parity and stop-bit checking
// rev 1.0
// ==========================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [Data_width-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int c_bcw = (Data_width > 1) ? $clog2(Data_width) : 1;
  localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(Data_width - 1);

  state_e                state_d, state_q;
  logic [5:0]            edge_cnt_d, edge_cnt_q;
  logic [c_bcw-1:0]      bit_cnt_d, bit_cnt_q;
  logic [5:0]            presc_d, presc_q;
  logic                  par_en_d, par_en_q;
  logic                  par_typ_d, par_typ_q;
  logic [Data_width-1:0] shift_d, shift_q;
  logic                  par_err_d, par_err_q;
  logic [Data_width-1:0] p_data_d, p_data_q;
  logic                  data_valid_d, data_valid_q;
  logic                  parity_error_d, parity_error_q;
  logic                  stop_error_d, stop_error_q;

  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  bit_end;
  logic [Data_width:0]   shift_ext;

  data_sampling u_data_sampling (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (presc_q),
    .edge_cnt     (edge_cnt_q),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  assign bit_end   = (edge_cnt_q == presc_q - 6'd1) && sample_valid;
  assign shift_ext = {sampled_bit, shift_q};

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d      = bit_cnt_q;
    presc_d        = presc_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = '0;
        // The detecting edge is frame edge 0; frame config is frozen here.
        if (!RX_IN) begin
          state_d   = START;
          presc_d   = legal_prescale(Prescale);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_ext[Data_width:1];
          if (bit_cnt_q == c_last_bit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d        = IDLE;
          stop_error_d   = ~sampled_bit;
          parity_error_d = par_err_q;
          if (sampled_bit && !par_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      edge_cnt_q     <= 6'd0;
      bit_cnt_q      <= '0;
      presc_q        <= PRESCALE_8;
      par_en_q       <= 1'b0;
      par_typ_q      <= PAR_EVEN;
      shift_q        <= '0;
      par_err_q      <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      presc_q        <= presc_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule

`default_nettype wire
